// File: rtl/alu_ops_pkg.sv
// ALU function codes and sequencer state shared by the ALU
// and the operation sequencer that feeds it.
package alu_ops_pkg;

  localparam logic [2:0] FN_ADD4C = 3'b000;
  localparam logic [2:0] FN_ADD   = 3'b001;
  localparam logic [2:0] FN_SEXT  = 3'b010;
  localparam logic [2:0] FN_OR    = 3'b011;
  localparam logic [2:0] FN_AND   = 3'b100;
  localparam logic [2:0] FN_CAT   = 3'b101;
  localparam logic [2:0] FN_MUL   = 3'b110;
  localparam logic [2:0] FN_HOLD  = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } seq_state_t;

endpackage

// File: rtl/op_mem.sv
// Program store: one synchronous write port, one
// combinational read port, no reset on the contents.
module op_mem #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 7
) (
  input  logic                     Clock,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [WIDTH-1:0]         wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [WIDTH-1:0]         rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge Clock) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/alu_op_sequencer.sv
// Loads a short {Function, Data} program and replays it into
// the registered ALU, free-running or one entry per step.
module alu_op_sequencer
  import alu_ops_pkg::*;
#(
  parameter int DEPTH  = 8,
  parameter int DATA_W = 4,
  parameter int FUNC_W = 3
) (
  input  logic                     Clock,
  input  logic                     Reset_b,
  input  logic                     wr_en,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic [FUNC_W-1:0]        wr_func,
  input  logic                     clear,
  input  logic                     start,
  input  logic                     step_mode,
  input  logic                     step,
  output logic [DATA_W-1:0]        Data,
  output logic [FUNC_W-1:0]        Function,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     busy,
  output logic                     done
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int EW = FUNC_W + DATA_W;

  localparam logic [CW-1:0]     ONE   = CW'(1);
  localparam logic [CW-1:0]     FULLC = CW'(DEPTH);
  localparam logic [FUNC_W-1:0] HOLD  = FUNC_W'(FN_HOLD);

  seq_state_t    state;
  logic [CW-1:0] pc;
  logic          step_q;
  logic [EW-1:0] rd_entry;
  logic          accept_wr;
  logic          issue;

  assign full = (count == FULLC);

  // start outranks wr_en, so a simultaneous write is dropped
  assign accept_wr = wr_en && !start && !clear &&
                     !full && (state != ST_RUN);

  assign issue = (state == ST_RUN) && (pc != count) &&
                 (!step_q || step);

  op_mem #(
    .DEPTH (DEPTH),
    .WIDTH (EW)
  ) u_mem (
    .Clock (Clock),
    .we    (accept_wr),
    .waddr (count[AW-1:0]),
    .wdata ({wr_func, wr_data}),
    .raddr (pc[AW-1:0]),
    .rdata (rd_entry)
  );

  always_ff @(posedge Clock or negedge Reset_b) begin
    if (!Reset_b) begin
      state    <= ST_IDLE;
      count    <= '0;
      pc       <= '0;
      step_q   <= 1'b0;
      Data     <= '0;
      Function <= HOLD;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      Data     <= '0;
      Function <= HOLD;
      if (clear) begin
        state <= ST_IDLE;
        count <= '0;
        pc    <= '0;
        busy  <= 1'b0;
        done  <= 1'b0;
      end else begin
        unique case (state)
          ST_IDLE: begin
            if (start) begin
              if (count != '0) begin
                state  <= ST_RUN;
                pc     <= '0;
                step_q <= step_mode;
                busy   <= 1'b1;
              end
            end else if (accept_wr) begin
              count <= count + ONE;
            end
          end
          ST_RUN: begin
            if (pc == count) begin
              state <= ST_DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else if (issue) begin
              {Function, Data} <= rd_entry;
              pc <= pc + ONE;
            end
          end
          ST_DONE: begin
            if (start) begin
              state  <= ST_RUN;
              pc     <= '0;
              step_q <= step_mode;
              busy   <= 1'b1;
              done   <= 1'b0;
            end else if (wr_en) begin
              state <= ST_IDLE;
              done  <= 1'b0;
              if (accept_wr) begin
                count <= count + ONE;
              end
            end
          end
          default: begin
            state <= ST_IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Bench for alu_op_sequencer with a behavioural ALU downstream
// and a program-list reference for the issued entries.
module tb_alu_op_sequencer;

  localparam int DEPTH = 8;
  localparam logic [6:0] HOLD7 = 7'b111_0000;

  logic       Clock = 1'b0;
  logic       Reset_b = 1'b0;
  logic       wr_en = 1'b0;
  logic [3:0] wr_data = '0;
  logic [2:0] wr_func = '0;
  logic       clear = 1'b0;
  logic       start = 1'b0;
  logic       step_mode = 1'b0;
  logic       step = 1'b0;
  logic [3:0] Data;
  logic [2:0] Function;
  logic [3:0] count;
  logic       full;
  logic       busy;
  logic       done;

  logic [7:0] alu_q;
  int         n_pass = 0;
  int         n_total = 0;
  logic [6:0] prog[$];

  always #5 Clock = ~Clock;

  alu_op_sequencer #(
    .DEPTH  (DEPTH),
    .DATA_W (4),
    .FUNC_W (3)
  ) dut (
    .Clock     (Clock),
    .Reset_b   (Reset_b),
    .wr_en     (wr_en),
    .wr_data   (wr_data),
    .wr_func   (wr_func),
    .clear     (clear),
    .start     (start),
    .step_mode (step_mode),
    .step      (step),
    .Data      (Data),
    .Function  (Function),
    .count     (count),
    .full      (full),
    .busy      (busy),
    .done      (done)
  );

  function automatic logic [7:0] alu_next(input logic [7:0] acc,
                                          input logic [3:0] a,
                                          input logic [2:0] f);
    logic [3:0] b;
    b = acc[3:0];
    case (f)
      3'd0: return {3'b000, 5'(a) + 5'(b)};
      3'd1: return 8'(a) + 8'(b);
      3'd2: return {{4{b[3]}}, b};
      3'd3: return {7'b0, |{a, b}};
      3'd4: return {7'b0, &{a, b}};
      3'd5: return {a, b};
      3'd6: return 8'(a) * 8'(b);
      default: return acc;
    endcase
  endfunction

  always @(posedge Clock or negedge Reset_b) begin
    if (!Reset_b) alu_q <= 8'h00;
    else alu_q <= alu_next(alu_q, Data, Function);
  end

  task automatic tick;
    @(posedge Clock);
    #1;
  endtask

  task automatic do_reset;
    wr_en = 0; clear = 0; start = 0; step = 0; step_mode = 0;
    Reset_b = 1'b0;
    repeat (2) @(posedge Clock);
    #1 Reset_b = 1'b1;
  endtask

  task automatic do_clear;
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  task automatic load_entry(input logic [6:0] e);
    wr_en = 1'b1;
    {wr_func, wr_data} = e;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic load_random(input int n);
    logic [6:0] e;
    prog.delete();
    for (int i = 0; i < n; i++) begin
      e = {3'($urandom_range(0, 6)), 4'($urandom)};
      prog.push_back(e);
      load_entry(e);
    end
  endtask

  task automatic test_reset;
    do_reset();
    n_total++;
    if ({Function, Data} !== HOLD7 || count !== 4'd0 ||
        busy !== 1'b0 || done !== 1'b0 || full !== 1'b0)
      $display("FAIL reset_state: fd=%h cnt=%0d b=%b d=%b f=%b need fd=70 0 0 0 0",
               {Function, Data}, count, busy, done, full);
    else n_pass++;
    load_entry(7'b001_0101);
    load_entry(7'b011_1010);
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    n_total++;
    if ({Function, Data} !== 7'b001_0101)
      $display("FAIL reset_prerun: fd=%h need 15", {Function, Data});
    else n_pass++;
    @(negedge Clock);
    #1 Reset_b = 1'b0;
    #1;
    n_total++;
    if ({Function, Data} !== HOLD7 || count !== 4'd0 ||
        busy !== 1'b0 || done !== 1'b0)
      $display("FAIL reset_async: fd=%h cnt=%0d b=%b d=%b need 70 0 0 0",
               {Function, Data}, count, busy, done);
    else n_pass++;
    @(posedge Clock);
    #1 Reset_b = 1'b1;
  endtask

  task automatic test_free_run;
    logic [7:0] exp_alu [3];
    exp_alu = '{8'h03, 8'h06, 8'h16};
    do_reset();
    prog = '{7'b001_0011, 7'b110_0010, 7'b101_0001};
    foreach (prog[i]) load_entry(prog[i]);
    step_mode = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      n_total++;
      if ({Function, Data} !== prog[k] || busy !== 1'b1 || done !== 1'b0)
        $display("FAIL free_issue%0d: fd=%h b=%b d=%b need %h 1 0",
                 k, {Function, Data}, busy, done, prog[k]);
      else n_pass++;
      if (k > 0) begin
        n_total++;
        if (alu_q !== exp_alu[k-1])
          $display("FAIL free_alu%0d: alu=%h need %h", k - 1, alu_q, exp_alu[k-1]);
        else n_pass++;
      end
    end
    tick();
    n_total++;
    if ({Function, Data} !== HOLD7 || done !== 1'b1 ||
        busy !== 1'b0 || alu_q !== 8'h16)
      $display("FAIL free_done: fd=%h d=%b b=%b alu=%h need 70 1 0 16",
               {Function, Data}, done, busy, alu_q);
    else n_pass++;
  endtask

  task automatic test_step_mode;
    logic [7:0] exp_alu [3];
    logic [7:0] prev;
    int w;
    exp_alu = '{8'h03, 8'h06, 8'h16};
    do_reset();
    prog = '{7'b001_0011, 7'b110_0010, 7'b101_0001};
    foreach (prog[i]) load_entry(prog[i]);
    step_mode = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    step_mode = 1'b0;
    for (int k = 0; k < 3; k++) begin
      prev = (k == 0) ? 8'h00 : exp_alu[k-1];
      for (int g = 0; g < 4; g++) begin
        tick();
        n_total++;
        if ({Function, Data} !== HOLD7 || alu_q !== prev || busy !== 1'b1)
          $display("FAIL step_gap%0d_%0d: fd=%h alu=%h b=%b need 70 %h 1",
                   k, g, {Function, Data}, alu_q, busy, prev);
        else n_pass++;
      end
      step = 1'b1;
      tick();
      step = 1'b0;
      n_total++;
      if ({Function, Data} !== prog[k] || alu_q !== prev)
        $display("FAIL step_issue%0d: fd=%h alu=%h need %h %h",
                 k, {Function, Data}, alu_q, prog[k], prev);
      else n_pass++;
    end
    tick();
    n_total++;
    if ({Function, Data} !== HOLD7 || alu_q !== 8'h16)
      $display("FAIL step_final: fd=%h alu=%h need 70 16", {Function, Data}, alu_q);
    else n_pass++;
    w = 0;
    while (done !== 1'b1 && w < 4) begin
      tick();
      w++;
    end
    n_total++;
    if (done !== 1'b1 || {Function, Data} !== HOLD7)
      $display("FAIL step_done: d=%b fd=%h need 1 70", done, {Function, Data});
    else n_pass++;
  endtask

  task automatic test_full;
    logic [6:0] e;
    do_clear();
    prog.delete();
    for (int i = 0; i < 9; i++) begin
      e = {3'($urandom_range(0, 6)), 4'($urandom)};
      if (i < DEPTH) prog.push_back(e);
      load_entry(e);
    end
    n_total++;
    if (count !== 4'd8 || full !== 1'b1)
      $display("FAIL full_count: cnt=%0d full=%b need 8 1", count, full);
    else n_pass++;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < DEPTH; k++) begin
      tick();
      n_total++;
      if ({Function, Data} !== prog[k])
        $display("FAIL full_issue%0d: fd=%h need %h", k, {Function, Data}, prog[k]);
      else n_pass++;
    end
    tick();
    n_total++;
    if ({Function, Data} !== HOLD7 || done !== 1'b1)
      $display("FAIL full_no9th: fd=%h d=%b need 70 1", {Function, Data}, done);
    else n_pass++;
  endtask

  task automatic test_abort;
    do_clear();
    load_random(4);
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    n_total++;
    if (busy !== 1'b0 || done !== 1'b0 || count !== 4'd0 ||
        {Function, Data} !== HOLD7)
      $display("FAIL abort_clear: b=%b d=%b cnt=%0d fd=%h need 0 0 0 70",
               busy, done, count, {Function, Data});
    else n_pass++;
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    n_total++;
    if (busy !== 1'b0 || {Function, Data} !== HOLD7)
      $display("FAIL abort_start_ignored: b=%b fd=%h need 0 70", busy, {Function, Data});
    else n_pass++;
  endtask

  task automatic test_simultaneous;
    do_clear();
    load_random(2);
    start = 1'b1;
    wr_en = 1'b1;
    {wr_func, wr_data} = 7'b010_1111;
    tick();
    start = 1'b0;
    wr_en = 1'b0;
    n_total++;
    if (busy !== 1'b1 || count !== 4'd2)
      $display("FAIL simul_start: b=%b cnt=%0d need 1 2", busy, count);
    else n_pass++;
    for (int k = 0; k < 2; k++) begin
      tick();
      n_total++;
      if ({Function, Data} !== prog[k])
        $display("FAIL simul_issue%0d: fd=%h need %h", k, {Function, Data}, prog[k]);
      else n_pass++;
    end
    tick();
    n_total++;
    if (done !== 1'b1 || count !== 4'd2 || {Function, Data} !== HOLD7)
      $display("FAIL simul_done: d=%b cnt=%0d fd=%h need 1 2 70",
               done, count, {Function, Data});
    else n_pass++;
  endtask

  task automatic test_done_replay;
    logic [6:0] e;
    do_clear();
    load_random(3);
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (4) tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    n_total++;
    if (busy !== 1'b1 || done !== 1'b0)
      $display("FAIL replay_start: b=%b d=%b need 1 0", busy, done);
    else n_pass++;
    tick();
    n_total++;
    if ({Function, Data} !== prog[0])
      $display("FAIL replay_first: fd=%h need %h", {Function, Data}, prog[0]);
    else n_pass++;
    repeat (3) tick();
    e = 7'b100_1001;
    prog.push_back(e);
    load_entry(e);
    n_total++;
    if (count !== 4'd4 || busy !== 1'b0 || done !== 1'b0)
      $display("FAIL done_append: cnt=%0d b=%b d=%b need 4 0 0", count, busy, done);
    else n_pass++;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (4) tick();
    n_total++;
    if ({Function, Data} !== e)
      $display("FAIL append_issue: fd=%h need %h", {Function, Data}, e);
    else n_pass++;
  endtask

  task automatic test_random;
    logic       mode;
    logic       s;
    logic [6:0] expv;
    int         idx;
    int         n;
    for (int r = 0; r < 6; r++) begin
      do_clear();
      n = $urandom_range(1, DEPTH);
      load_random(n);
      mode = 1'($urandom_range(0, 1));
      step_mode = mode;
      start = 1'b1;
      tick();
      start = 1'b0;
      step_mode = ~mode;
      idx = 0;
      for (int c = 0; c < 60; c++) begin
        s = 1'($urandom_range(0, 1));
        step = s;
        tick();
        step = 1'b0;
        if (idx == n) break;
        expv = HOLD7;
        if (!mode || s) begin
          expv = prog[idx];
          idx++;
        end
        n_total++;
        if ({Function, Data} !== expv)
          $display("FAIL rand%0d_c%0d: fd=%h need %h", r, c, {Function, Data}, expv);
        else n_pass++;
      end
      n_total++;
      if (done !== 1'b1 || {Function, Data} !== HOLD7 || idx != n)
        $display("FAIL rand%0d_done: d=%b fd=%h issued=%0d need 1 70 %0d",
                 r, done, {Function, Data}, idx, n);
      else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_free_run();
    test_step_mode();
    test_full();
    test_abort();
    test_simultaneous();
    test_done_replay();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
